// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared types and constants for the sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUNNING = 2'd2,
        DONE    = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_controller.sv
`default_nettype none
// ============================================================================
// Module      : div_controller
// Description : IDLE/LOAD/RUNNING/DONE sequencer and iteration counter for the
//               restoring divider. Emits load/step/finish strobes and busy.
// Revision    : 1.0 - initial release
// ============================================================================
module div_controller
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic start,
    input  logic div_zero,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    div_state_t       state;
    div_state_t       next_state;
    logic [CW-1:0]    count;

    // State register; busy is registered from the next state so it is a flop output
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    // Iteration counter: WIDTH-1 down to 0, last RUNNING cycle is the one at 0
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (state == LOAD) begin
            count <= LAST;
        end else if (state == RUNNING) begin
            count <= count - 1'b1;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = div_zero ? DONE : RUNNING;
            RUNNING: if (count == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign load   = (state == LOAD);
    assign step   = (state == RUNNING);
    assign finish = (state == DONE);

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module      : divider
// Description : Sequential restoring integer divider, one quotient bit per
//               clock, start/ready handshake. Define DIVIDER_SIGNED_EN for
//               two's-complement operands (truncating division).
// Revision    : 1.0 - initial release
// ============================================================================
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ready,
    output logic             busy
);

    logic             accept;
    logic             div_zero;
    logic             load;
    logic             step;
    logic             finish;
    logic [WIDTH-1:0] dd_cap;
    logic [WIDTH-1:0] dv_cap;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    assign accept   = start & ~busy;
    assign div_zero = (dv_cap == '0);

    div_controller #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start    (start),
        .div_zero (div_zero),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .busy     (busy)
    );

    // Operand capture on the accepting edge; held for sign recovery in DONE
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dd_cap <= '0;
            dv_cap <= '0;
        end else if (accept) begin
            dd_cap <= dividend;
            dv_cap <= divisor;
        end
    end

`ifdef DIVIDER_SIGNED_EN
    // Magnitudes of the captured operands; the most-negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
    assign dd_mag = dd_cap[WIDTH-1] ? -dd_cap : dd_cap;
    assign dv_mag = dv_cap[WIDTH-1] ? -dv_cap : dv_cap;
    // Quotient negative when signs differ; remainder follows the dividend
    assign res_q  = (dd_cap[WIDTH-1] ^ dv_cap[WIDTH-1]) ? -quo_r : quo_r;
    assign res_r  = dd_cap[WIDTH-1] ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
`else
    assign dd_mag = dd_cap;
    assign dv_mag = dv_cap;
    assign res_q  = quo_r;
    assign res_r  = rem_r[WIDTH-1:0];
`endif

    // Shift {rem,quo} left one, then trial-subtract the divisor; the extra
    // top bit of trial is the borrow that decides restore vs keep.
    assign rem_sh = {rem_r, quo_r[WIDTH-1]};
    assign trial  = rem_sh - {2'b00, dv_mag};

    // Working registers: initialised in LOAD, one restoring step per RUNNING cycle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rem_r <= '0;
            quo_r <= '0;
        end else if (load) begin
            rem_r <= '0;
            quo_r <= dd_mag;
        end else if (step) begin
            if (!trial[WIDTH+1]) begin
                rem_r <= trial[WIDTH:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= rem_sh[WIDTH:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Output registers: results and flag change only on the edge raising ready
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ready       <= 1'b0;
        end else begin
            ready <= finish;
            if (finish) begin
                if (div_zero) begin
                    quotient    <= '1;
                    remainder   <= dd_cap;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= res_q;
                    remainder   <= res_r;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
